serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial A − B − borrowIn engine; the inverse-direction companion of the team's parallel adder.
- Accepts operands and a borrow through a start handshake and resolves one bit per clock, LSB first.
- Returns a registered difference word and borrow-out with a one-cycle done pulse.
- Used where area matters more than latency, and as a cross-check against adder results.

Parameters:
- WIDTH, 4, operand and difference width in bits (≥2).
- CNT_W, $clog2(WIDTH), width of the bit-index counter (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- resetN  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  minuend, captured when start is accepted.
- b  input  WIDTH  subtrahend, captured when start is accepted.
- borrowIn  input  1  initial borrow, captured when start is accepted.
- busy  output  1  high while bits are being computed (SHIFT state).
- done  output  1  one-cycle pulse; diff/borrowOut are valid from this cycle.
- diff  output  WIDTH  registered result a − b − borrowIn mod 2^WIDTH.
- borrowOut  output  1  final borrow; 1 when a < b + borrowIn (unsigned).

Behaviour:
- Reset (resetN low, asynchronous): state=IDLE; busy=0, done=0, diff=0, borrowOut=0; shift registers and counter cleared. Reset mid-operation aborts with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 at an edge → capture a, b and borrowIn into shift regs and the borrow flop; clear diff; counter=0; go to SHIFT. start=0 → stay in IDLE.
- SHIFT (busy=1): each edge:
  - computes d = aReg[0]^bReg[0]^brw and brwNext = (~aReg[0]&bReg[0]) | (~(aReg[0]^bReg[0])&brw);
  - shifts d into diff from the MSB end; shifts aReg/bReg right; increments the counter.
  - When counter==WIDTH-1 at that edge → go to DONE, borrowOut=brwNext.
  - start is ignored in SHIFT; operand inputs are don't-care.
- DONE: done=1 and busy=0 for exactly one cycle; diff and borrowOut hold.
  - start=1 → accepted as in IDLE (back-to-back, no idle gap).
  - Otherwise → IDLE.
- Latency: start accepted at edge k → done high in the cycle following edge k+WIDTH. Throughput is one operation per WIDTH+1 cycles.
- diff and borrowOut hold their last values through IDLE until the next accepted start. diff clears at start acceptance; borrowOut updates only on entry to DONE.
- Widths: all arithmetic is modulo 2^WIDTH; no sign interpretation (see optional feature).

Optional Feature:
- Macro SERIAL_SUB_OVERFLOW_EN.
- Defined: adds output overflow (1 bit), set on entry to DONE to the signed (two's-complement) overflow of a − b − borrowIn, i.e. a[MSB]!=b[MSB] && diff[MSB]!=a[MSB]. aReg[MSB] is preserved in a sign flop at capture. overflow resets to 0 and holds like borrowOut.
- Undefined: no port, no sign flop; behaviour is otherwise identical.

Decomposition:
- Shared package serial_sub_pkg:
  - state enum {IDLE, SHIFT, DONE}, 2-bit encoding 00/01/10;
  - DEFAULT_WIDTH=4 constant.
- One natural sub-module: full_subtractor (combinational a, b, bin → d, bout), instantiated once for the per-bit step. It is reusable by a future ripple subtractor.

Test Plan:
- a=0101, b=0011, borrowIn=0, start pulse → busy for 4 cycles, done on cycle 5; diff=0010, borrowOut=0.
- a=0010, b=0100, borrowIn=0 → diff=1110, borrowOut=1; with the macro, overflow=0. Also a=1000, b=0001 → diff=0111, borrowOut=0, overflow=1.
- a=0000, b=0000, borrowIn=1 → diff=1111, borrowOut=1. a=1111, b=1111, borrowIn=0 → diff=0000, borrowOut=0.
- start held high with different a/b during SHIFT → ignored, result matches the first operands. start=1 in the DONE cycle with a=1011, b=0010, borrowIn=1 → second done exactly 5 cycles later with diff=1000, borrowOut=0.
- resetN pulled low asynchronously after 2 SHIFT cycles → all outputs 0 immediately, no done pulse. A fresh start after release completes normally.
- Random sweep over all 512 (a, b, borrowIn) combinations at WIDTH=4 against the reference model {borrowOut, diff} = {1'b0, a} − b − borrowIn, masked to 5 bits.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t       : FSM encoding (IDLE=00, SHIFT=01, DONE=10), also exported
//                   on the debug port of serial_subtractor.
//   DEFAULT_WIDTH : default operand width.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: a - b - bin.
// Ports:
//   a, b  : minuend and subtrahend bits
//   bin   : borrow in
//   d     : difference bit
//   bout  : borrow out (set when a < b + bin)
// Purely combinational, so a ripple subtractor can reuse it directly.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor computing a - b - borrowIn, one bit per clock, LSB first.
// Ports:
//   clk        : rising-edge clock
//   resetN     : asynchronous active-low reset
//   start      : request, accepted at an edge while in IDLE or DONE
//   a, b       : minuend / subtrahend, captured when start is accepted
//   borrowIn   : initial borrow, captured when start is accepted
//   busy       : high while bits are being computed (SHIFT)
//   done       : one-cycle pulse; diff/borrowOut valid from this cycle on
//   diff       : a - b - borrowIn mod 2^WIDTH, holds until the next accept
//   borrowOut  : final borrow, updated only on entry to DONE
//   overflow   : signed overflow of the subtraction; present only when
//                SERIAL_SUB_OVERFLOW_EN is defined
//   state_dbg  : current FSM state
//
// Handshake: there is no separate ready signal. busy low means the block is in
// IDLE or DONE, and a start seen high at the next rising edge is accepted and
// its operands captured; start is ignored while busy is high.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrowIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrowOut,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic             overflow,
`endif
  output state_t           state_dbg
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic               brw;
  logic [CNT_W-1:0]   cnt;
  logic               bit_d;
  logic               bit_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic               sign_a;
`endif

  assign state_dbg = state;

  // Per-bit step always works on the current LSBs and the running borrow.
  full_subtractor u_bit (
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .bin  (brw),
    .d    (bit_d),
    .bout (bit_bout)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      brw       <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      diff      <= '0;
      borrowOut <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      sign_a    <= 1'b0;
      overflow  <= 1'b0;
`endif
    end else begin
      case (state)
        // IDLE and DONE share the accept path so DONE can chain straight
        // into the next operation without an idle cycle.
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            brw   <= borrowIn;
            diff  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
`ifdef SERIAL_SUB_OVERFLOW_EN
            sign_a <= a[WIDTH-1];
`endif
          end else begin
            state <= IDLE;
          end
        end

        SHIFT: begin
          // Result bits enter at the MSB so after WIDTH steps bit 0 of the
          // operands has landed in diff[0].
          diff  <= {bit_d, diff[WIDTH-1:1]};
          a_reg <= a_reg >> 1;
          b_reg <= b_reg >> 1;
          brw   <= bit_bout;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            borrowOut <= bit_bout;
            state     <= DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
            // On the last step b_reg[0] is b's sign bit and bit_d is the
            // result's sign bit.
            overflow  <= (sign_a != b_reg[0]) && (bit_d != sign_a);
`endif
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: directed cases plus a shuffled sweep over
// every (a, b, borrowIn) combination. A driver pushes expected words
// {overflow, borrowOut, diff} into exp_q; a monitor pops and compares on
// every done pulse. Build with +define+SERIAL_SUB_OVERFLOW_EN to cover the
// overflow output.
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  localparam int WIDTH = 4;
  localparam int EW    = WIDTH + 2;
`ifdef SERIAL_SUB_OVERFLOW_EN
  localparam bit HAS_OVF = 1'b1;
`else
  localparam bit HAS_OVF = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             resetN = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             borrowIn = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrowOut;
  logic             ovf_act;
  state_t           state_dbg;

  always #5 clk = ~clk;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic overflow;
  assign ovf_act = overflow;
`else
  assign ovf_act = 1'b0;
`endif

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .start     (start),
    .a         (a),
    .b         (b),
    .borrowIn  (borrowIn),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrowOut (borrowOut),
`ifdef SERIAL_SUB_OVERFLOW_EN
    .overflow  (overflow),
`endif
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;
  int n_checks = 0;
  int n_errors = 0;
  int n_pushed = 0;
  int done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: no done within cycle budget at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  // Unsigned view: {borrow, diff} is the (WIDTH+1)-bit two's-complement
  // truncation of a - b - bin.
  function automatic logic [WIDTH:0] model_word(input int av, input int bv, input int bin);
    int r;
    r = av - bv - bin;
    return r[WIDTH:0];
  endfunction

  // Signed view: overflow when the true signed result leaves WIDTH-bit range.
  function automatic logic model_ovf(input int av, input int bv, input int bin);
    int sa, sb, r;
    sa = (av >= 2 ** (WIDTH - 1)) ? av - 2 ** WIDTH : av;
    sb = (bv >= 2 ** (WIDTH - 1)) ? bv - 2 ** WIDTH : bv;
    r  = sa - sb - bin;
    return (r < -(2 ** (WIDTH - 1))) || (r > 2 ** (WIDTH - 1) - 1);
  endfunction

  function automatic logic [EW-1:0] model_exp(input int av, input int bv, input int bin);
    return {HAS_OVF & model_ovf(av, bv, bin), model_word(av, bv, bin)};
  endfunction

  task automatic push_exp(input logic [EW-1:0] e);
    exp_q.push_back(e);
    n_pushed++;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (resetN && done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got done with diff=0x%0h, expected no done at %0t", diff, $time);
      end else begin
        exp_e = exp_q.pop_front();
        check("result", {ovf_act, borrowOut, diff}, exp_e);
        check("busy_at_done", busy, 1'b0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(output int busy_cycles, output int done_cycle);
    bit found;
    found = 1'b0;
    busy_cycles = 0;
    done_cycle = 0;
    for (int i = 0; i < 4 * WIDTH + 8 && !found; i++) begin
      @(negedge clk);
      done_cycle++;
      if (done) found = 1'b1;
      else if (busy) busy_cycles++;
    end
    if (!found) timeout_fail("wait_done");
  endtask

  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic bin, input logic [EW-1:0] e,
                        output int busy_cycles, output int done_cycle);
    @(posedge clk); #1;
    a = av; b = bv; borrowIn = bin; start = 1'b1;
    push_exp(e);
    @(posedge clk); #1;
    start = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    borrowIn = 1'($urandom);
    wait_done(busy_cycles, done_cycle);
  endtask

  // ---------------- stimulus ----------------
  int bc, dc;
  int order[512];
  int idx, j, tmp;
  bit found2;

  initial begin
    // Reset state
    resetN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", diff, '0);
    check("rst_borrow", borrowOut, 1'b0);
    check("rst_ovf", ovf_act, 1'b0);
    check("rst_state", state_dbg, IDLE);
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk); #1;
    check("idle_state", state_dbg, IDLE);

    // Basic timing and value: 5 - 3 - 0
    run_op(4'b0101, 4'b0011, 1'b0, {1'b0, 1'b0, 4'b0010}, bc, dc);
    check("t1_busy_cycles", bc, WIDTH);
    check("t1_done_cycle", dc, WIDTH + 1);
    @(posedge clk); #1;
    check("t1_hold_diff", diff, 4'b0010);
    check("t1_back_idle", state_dbg, IDLE);

    // Boundary cases
    run_op(4'b0010, 4'b0100, 1'b0, {1'b0, 1'b1, 4'b1110}, bc, dc);
    run_op(4'b1000, 4'b0001, 1'b0, {HAS_OVF, 1'b0, 4'b0111}, bc, dc);
    run_op(4'b0000, 4'b0000, 1'b1, {1'b0, 1'b1, 4'b1111}, bc, dc);
    run_op(4'b1111, 4'b1111, 1'b0, {1'b0, 1'b0, 4'b0000}, bc, dc);
    check("hold_borrow_idle", borrowOut, 1'b0);

    // start held through SHIFT with changing operands, then chained in DONE
    @(posedge clk); #1;
    a = 4'b0110; b = 4'b0001; borrowIn = 1'b0; start = 1'b1;
    push_exp({1'b0, 1'b0, 4'b0101});
    @(posedge clk); #1;
    found2 = 1'b0;
    for (int i = 0; i < 4 * WIDTH + 8 && !found2; i++) begin
      @(negedge clk);
      if (done) found2 = 1'b1;
      else begin
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        borrowIn = 1'($urandom);
      end
    end
    if (!found2) timeout_fail("held_start_first");
    a = 4'b1011; b = 4'b0010; borrowIn = 1'b1;
    push_exp({1'b0, 1'b0, 4'b1000});
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(bc, dc);
    check("b2b_gap", dc, WIDTH + 1);

    // Asynchronous reset in the middle of SHIFT
    @(posedge clk); #1;
    a = 4'b0000; b = 4'b0001; borrowIn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("mid_busy", busy, 1'b1);
    check("mid_diff", diff, 4'b1100);
    resetN = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_diff", diff, '0);
    check("arst_borrow", borrowOut, 1'b0);
    check("arst_state", state_dbg, IDLE);
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    repeat (WIDTH + 3) @(posedge clk);
    run_op(4'b0111, 4'b0010, 1'b0, {1'b0, 1'b0, 4'b0101}, bc, dc);
    check("post_rst_done_cycle", dc, WIDTH + 1);

    // Shuffled sweep over every (a, b, borrowIn)
    for (int i = 0; i < 512; i++) order[i] = i;
    for (int i = 511; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 512; i++) begin
      idx = order[i];
      repeat ($urandom_range(0, 2)) @(posedge clk);
      run_op(idx[3:0], idx[7:4], idx[8],
             model_exp(int'(idx[3:0]), int'(idx[7:4]), int'(idx[8])), bc, dc);
    end

    // Drain and close out
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("done_count", done_seen, n_pushed);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
